// File: rtl/led_seq_gen.sv
// LED pattern sequencer: dot, bar, bounce-dot and blink patterns over N_LEDS
// outputs, advanced by a programmable step prescaler.
//
// Bounce direction register:
//   state  | meaning
//   B_UP   | bounce walking toward LED N_LEDS-1
//   B_DOWN | bounce walking back toward LED0
module led_seq_gen #(
  parameter  int N_LEDS = 10,
  parameter  int DIV_W  = 8,
  localparam int POS_W  = $clog2(N_LEDS)
) (
  input  logic              ck,
  input  logic              rs,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [DIV_W-1:0]  div,
  output logic [POS_W-1:0]  pos,
  output logic [N_LEDS-1:0] leds,
  output logic              wrap
);

  typedef enum logic [1:0] {
    M_DOT    = 2'b00,
    M_BAR    = 2'b01,
    M_BOUNCE = 2'b10,
    M_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    B_UP   = 1'b0,
    B_DOWN = 1'b1
  } bdir_t;

  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

  logic [DIV_W-1:0]  r_presc;
  logic [POS_W-1:0]  r_pos;
  mode_t             r_mode;
  bdir_t             r_bdir;
  logic              r_phase;
  logic              r_wrap;
  // Sampled copy of dir so the bar decode depends only on registered state.
  logic              r_dir;

  logic              w_tick;
  logic [DIV_W-1:0]  w_presc_nx;
  logic [POS_W-1:0]  w_pos_nx;
  bdir_t             w_bdir_nx;
  logic              w_phase_nx;
  logic              w_wrap_nx;
  logic [N_LEDS-1:0] w_leds;

  // State register; reset overrides both step and mode change.
  always_ff @(posedge ck) begin
    if (rs) begin
      r_presc <= '0;
      r_pos   <= '0;
      r_mode  <= M_DOT;
      r_bdir  <= B_UP;
      r_phase <= 1'b0;
      r_wrap  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_presc <= w_presc_nx;
      r_pos   <= w_pos_nx;
      r_mode  <= mode_t'(mode);
      r_bdir  <= w_bdir_nx;
      r_phase <= w_phase_nx;
      r_wrap  <= w_wrap_nx;
      r_dir   <= dir;
    end
  end

  // Next-state: a mode change restarts the pattern, otherwise step on prescaler tick.
  always_comb begin
    w_tick     = 1'b0;
    w_presc_nx = r_presc;
    w_pos_nx   = r_pos;
    w_bdir_nx  = r_bdir;
    w_phase_nx = r_phase;
    w_wrap_nx  = 1'b0;
    if (mode != r_mode) begin
      w_presc_nx = '0;
      w_phase_nx = 1'b0;
      w_bdir_nx  = B_UP;
      w_pos_nx   = (mode != M_BOUNCE && dir) ? LAST : '0;
    end else if (en) begin
      if (r_presc >= div) begin
        w_tick     = 1'b1;
        w_presc_nx = '0;
      end else begin
        w_presc_nx = r_presc + 1'b1;
      end
      if (w_tick) begin
        if (r_mode == M_BOUNCE) begin
          // Reverse as soon as an endpoint is reached so it is shown for one step only.
          if (r_bdir == B_UP) begin
            w_pos_nx = r_pos + 1'b1;
            if (w_pos_nx == LAST) w_bdir_nx = B_DOWN;
          end else begin
            w_pos_nx = r_pos - 1'b1;
            if (w_pos_nx == '0) begin
              w_bdir_nx = B_UP;
              w_wrap_nx = 1'b1;
            end
          end
        end else begin
          if (!dir) begin
            if (r_pos == LAST) begin
              w_pos_nx  = '0;
              w_wrap_nx = 1'b1;
            end else begin
              w_pos_nx = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == '0) begin
              w_pos_nx  = LAST;
              w_wrap_nx = 1'b1;
            end else begin
              w_pos_nx = r_pos - 1'b1;
            end
          end
          if (r_mode == M_BLINK) w_phase_nx = ~r_phase;
        end
      end
    end
  end

  // LED decode from registered mode, position, direction and phase.
  always_comb begin
    w_leds = '0;
    case (r_mode)
      M_DOT, M_BOUNCE: w_leds = N_LEDS'(1) << r_pos;
      M_BAR: begin
        for (int i = 0; i < N_LEDS; i++) begin
          w_leds[i] = r_dir ? (POS_W'(i) >= r_pos) : (POS_W'(i) <= r_pos);
        end
      end
      M_BLINK: w_leds = {N_LEDS{r_phase}};
      default: w_leds = '0;
    endcase
  end

  assign pos  = r_pos;
  assign leds = w_leds;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_seq_gen.sv
// Bench for led_seq_gen: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a behavioural model, on a
// 10-LED and a 4-LED instance driven in parallel.
module tb_led_seq_gen;

  logic       ck;
  logic       rs;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] div;

  logic [3:0] pos10;
  logic [9:0] leds10;
  logic       wrap10;
  logic [1:0] pos4;
  logic [3:0] leds4;
  logic       wrap4;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  led_seq_gen #(.N_LEDS(10), .DIV_W(8)) dut10 (
    .ck(ck), .rs(rs), .en(en), .mode(mode), .dir(dir), .div(div),
    .pos(pos10), .leds(leds10), .wrap(wrap10)
  );

  led_seq_gen #(.N_LEDS(4), .DIV_W(8)) dut4 (
    .ck(ck), .rs(rs), .en(en), .mode(mode), .dir(dir), .div(div),
    .pos(pos4), .leds(leds4), .wrap(wrap4)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Model state: bounce is tracked as an index k into a period of 2n-2 steps.
  typedef struct {
    int pos;
    int presc;
    int phase;
    int bk;
    int modeq;
    int dirq;
    int wrap;
  } mst_t;

  mst_t m10;
  mst_t m4;

  function automatic mst_t mstep(mst_t s, int n, bit r, bit e, int md, int d, int dv);
    mst_t t;
    bit   tick;
    t = s;
    t.wrap = 0;
    if (r) begin
      t.pos = 0; t.presc = 0; t.phase = 0; t.bk = 0; t.modeq = 0; t.dirq = 0;
      return t;
    end
    t.modeq = md;
    t.dirq  = d;
    if (md != s.modeq) begin
      t.presc = 0; t.phase = 0; t.bk = 0;
      t.pos = (md != 2 && d != 0) ? n - 1 : 0;
      return t;
    end
    if (!e) return t;
    tick = (s.presc >= dv);
    t.presc = tick ? 0 : s.presc + 1;
    if (!tick) return t;
    if (s.modeq == 2) begin
      t.bk   = (s.bk + 1) % (2 * n - 2);
      t.pos  = (t.bk <= n - 1) ? t.bk : 2 * n - 2 - t.bk;
      t.wrap = (t.bk == 0) ? 1 : 0;
    end else begin
      if (d == 0) begin
        t.pos  = (s.pos + 1) % n;
        t.wrap = (s.pos == n - 1) ? 1 : 0;
      end else begin
        t.pos  = (s.pos + n - 1) % n;
        t.wrap = (s.pos == 0) ? 1 : 0;
      end
      if (s.modeq == 3) t.phase = 1 - s.phase;
    end
    return t;
  endfunction

  function automatic logic [31:0] exp_leds(mst_t s, int n);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < n; b++) begin
      case (s.modeq)
        0, 2:    v[b] = (b == s.pos);
        1:       v[b] = (s.dirq != 0) ? (b >= s.pos) : (b <= s.pos);
        default: v[b] = (s.phase != 0);
      endcase
    end
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ck);
    #2;
  endtask

  // Model advances on the same edge as the DUTs, from the same settled inputs.
  always @(posedge ck) begin
    m10 = mstep(m10, 10, rs, en, int'(mode), int'(dir), int'(div));
    m4  = mstep(m4,  4,  rs, en, int'(mode), int'(dir), int'(div));
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge ck) begin
    if (chk_on) begin
      chk("pos10",  32'(pos10),  32'(m10.pos));
      chk("leds10", 32'(leds10), exp_leds(m10, 10));
      chk("wrap10", 32'(wrap10), 32'(m10.wrap));
      chk("pos4",   32'(pos4),   32'(m4.pos));
      chk("leds4",  32'(leds4),  exp_leds(m4, 4));
      chk("wrap4",  32'(wrap4),  32'(m4.wrap));
    end
  end

  initial begin
    int          bseq [8];
    int          p;
    logic [31:0] full;
    logic [31:0] lv;
    logic [31:0] blink_exp;

    bseq = '{1, 2, 3, 2, 1, 0, 1, 2};
    full = 32'h3FF;
    rs = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0; div = 8'd0;

    repeat (2) cyc();
    chk("rst_pos",  32'(pos10),  32'd0);
    chk("rst_leds", 32'(leds10), 32'h001);
    chk("rst_wrap", 32'(wrap10), 32'd0);
    chk_on = 1;
    rs = 1'b0;

    // Dot, up, step every cycle.
    for (int i = 1; i <= 12; i++) begin
      cyc();
      lv = 32'd1 << (i % 10);
      chk("dot_leds", 32'(leds10), lv);
      chk("dot_wrap", 32'(wrap10), 32'((i % 10) == 0));
    end

    // Bar, down, step every 4 cycles.
    mode = 2'b01; dir = 1'b1; div = 8'd3;
    cyc();
    chk("bar_start_pos",  32'(pos10),  32'd9);
    chk("bar_start_leds", 32'(leds10), 32'h200);
    chk("bar_start_wrap", 32'(wrap10), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      repeat (4) cyc();
      p  = (19 - k) % 10;
      lv = (full >> p) << p;
      chk("bar_pos",  32'(pos10),  32'(p));
      chk("bar_leds", 32'(leds10), lv);
      chk("bar_wrap", 32'(wrap10), 32'(k == 10));
    end

    // Bounce on the 4-LED instance.
    mode = 2'b10; dir = 1'b0; div = 8'd0;
    cyc();
    chk("bnc_start", 32'(pos4), 32'd0);
    for (int j = 0; j < 8; j++) begin
      cyc();
      chk("bnc_pos",  32'(pos4),  32'(bseq[j]));
      chk("bnc_wrap", 32'(wrap4), 32'(bseq[j] == 0));
    end

    // Blink with div=1, then a 5-cycle enable drop.
    mode = 2'b11; div = 8'd1;
    cyc();
    chk("blk_start", 32'(leds10), 32'h000);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      blink_exp = (((c / 2) % 2) != 0) ? 32'h3FF : 32'h000;
      chk("blk_leds", 32'(leds10), blink_exp);
    end
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("frz_leds", 32'(leds10), 32'h3FF);
      chk("frz_pos",  32'(pos10),  32'd3);
      chk("frz_wrap", 32'(wrap10), 32'd0);
    end
    en = 1'b1;
    for (int c = 7; c <= 10; c++) begin
      cyc();
      blink_exp = (((c / 2) % 2) != 0) ? 32'h3FF : 32'h000;
      chk("blk_resume", 32'(leds10), blink_exp);
    end

    // Mode change dot -> bar while pos=6.
    mode = 2'b00; dir = 1'b0; div = 8'd0;
    cyc();
    repeat (6) cyc();
    chk("mc_pre_pos", 32'(pos10), 32'd6);
    mode = 2'b01;
    cyc();
    chk("mc_pos",  32'(pos10),  32'd0);
    chk("mc_leds", 32'(leds10), 32'h001);
    chk("mc_wrap", 32'(wrap10), 32'd0);
    cyc();
    chk("mc_step", 32'(leds10), 32'h003);

    // Reset on a wrapping tick at pos=9.
    mode = 2'b00;
    cyc();
    repeat (9) cyc();
    chk("rt_pre_pos", 32'(pos10), 32'd9);
    rs = 1'b1;
    cyc();
    chk("rt_pos",  32'(pos10),  32'd0);
    chk("rt_leds", 32'(leds10), 32'h001);
    chk("rt_wrap", 32'(wrap10), 32'd0);
    rs = 1'b0;
    cyc();
    chk("rt_restart", 32'(leds10), 32'h002);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rs = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) div = 8'($urandom_range(0, 5));
      if (en && $urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
    end
    cyc();
    chk_on = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
